clk_gate_ctrl: RTL and testbench

// - Sequences the enable of a downstream clk_gate instance on behalf of NUM_REQ requesters.
// - Opens the gate on any request and waits a fixed wake-up time before acknowledging.
// - Keeps the gate open for a programmable idle hysteresis after the last request drops.
// - Sits next to the clk_gate in glbl; its ena_o drives clk_gate ena_i. It runs on the free-running clock.
//

---
 rtl/clk_gate_ctrl_if.sv | 24 ++
 rtl/clk_gate_ctrl.sv | 98 +++++++++
 tb/tb_clk_gate_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// Request/enable bundle between clock requesters and the clk_gate sequencer.
// master drives requests and hold time; slave is the sequencer.
interface clk_gate_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned HOLD_W  = 8
);
  logic [NUM_REQ-1:0] req_i;
  logic               force_i;
  logic [HOLD_W-1:0]  hold_i;
  logic               ena_o;
  logic               on_o;
  logic [NUM_REQ-1:0] ack_o;
  logic               busy_o;

  modport master (
    output req_i, force_i, hold_i,
    input  ena_o, on_o, ack_o, busy_o
  );

  modport slave (
    input  req_i, force_i, hold_i,
    output ena_o, on_o, ack_o, busy_o
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable sequencer: opens on any request, waits WAKE_CYC before
// granting, and holds the gate open hold_i idle cycles after the last request.
module clk_gate_ctrl #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned HOLD_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic               clk_i,
  input  logic               rst_an_i,
  clk_gate_ctrl_if.slave     gif
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [3:0] WAKE_LD = (WAKE_CYC == 0) ? 4'd0 : 4'(WAKE_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        wake_q, wake_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ena_q, on_q, busy_q;
  logic              any_req;

  assign any_req = (|gif.req_i) | gif.force_i;

  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_OFF: begin
        if (any_req) begin
          if (WAKE_CYC == 0) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_WAKE;
            wake_d  = WAKE_LD;
          end
        end
      end
      ST_WAKE: begin
        // Wake-up always runs to completion even if all requests vanish.
        if (wake_q == '0) state_d = ST_ON;
        else              wake_d  = wake_q - 4'd1;
      end
      ST_ON: begin
        if (!any_req) begin
          if (gif.hold_i == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_HOLD;
            hold_d  = gif.hold_i - HOLD_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (any_req) begin
          state_d = ST_ON;
          hold_d  = '0;
        end else if (hold_q == '0) begin
          state_d = ST_OFF;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs get their own flops, fed from next state, so ena_o never glitches.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q <= ST_OFF;
      wake_q  <= '0;
      hold_q  <= '0;
      ena_q   <= 1'b0;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      hold_q  <= hold_d;
      ena_q   <= (state_d != ST_OFF);
      on_q    <= (state_d == ST_ON) || (state_d == ST_HOLD);
      busy_q  <= (state_d != ST_OFF);
    end
  end

  assign gif.ena_o  = ena_q;
  assign gif.on_o   = on_q;
  assign gif.busy_o = busy_q;
  assign gif.ack_o  = gif.req_i & {NUM_REQ{on_q}};

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: two builds (WAKE_CYC=2 and WAKE_CYC=0) share stimulus
// and are compared each cycle against an open/idle-interval model.
module tb_clk_gate_ctrl;
  localparam int NR = 4;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic          frc = 1'b0;
  logic [HW-1:0] hold = HW'(3);

  always #5 clk = ~clk;

  clk_gate_ctrl_if #(.NUM_REQ(NR), .HOLD_W(HW)) if0 ();
  clk_gate_ctrl_if #(.NUM_REQ(NR), .HOLD_W(HW)) if1 ();

  assign if0.req_i = req;  assign if0.force_i = frc;  assign if0.hold_i = hold;
  assign if1.req_i = req;  assign if1.force_i = frc;  assign if1.hold_i = hold;

  clk_gate_ctrl #(.NUM_REQ(NR), .HOLD_W(HW), .WAKE_CYC(2)) dut0 (
    .clk_i(clk), .rst_an_i(rst_n), .gif(if0));
  clk_gate_ctrl #(.NUM_REQ(NR), .HOLD_W(HW), .WAKE_CYC(0)) dut1 (
    .clk_i(clk), .rst_an_i(rst_n), .gif(if1));

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: gate opens on a request edge, grants WAKE edges later, then closes
  // on the (hold+1)-th consecutive idle edge seen while granted.
  int wk [2] = '{2, 0};
  bit m_ena [2];
  bit m_on  [2];
  int m_since [2];
  int m_idle  [2];
  int m_hold  [2];
  bit any_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ena[i] = 0; m_on[i] = 0; m_since[i] = 0; m_idle[i] = 0; m_hold[i] = 0;
      end
    end else begin
      any_r = (|req) || frc;
      for (int i = 0; i < 2; i++) begin
        if (!m_ena[i]) begin
          if (any_r) begin
            m_ena[i] = 1; m_since[i] = 0; m_idle[i] = 0;
            m_on[i] = (wk[i] == 0);
          end
        end else if (!m_on[i]) begin
          m_since[i]++;
          if (m_since[i] == wk[i]) m_on[i] = 1;
        end else if (any_r) begin
          m_idle[i] = 0;
        end else begin
          if (m_idle[i] == 0) m_hold[i] = int'(hold);
          m_idle[i]++;
          if (m_idle[i] == m_hold[i] + 1) begin
            m_ena[i] = 0; m_on[i] = 0; m_idle[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ena0",  32'(if0.ena_o),  32'(m_ena[0]));
    chk("on0",   32'(if0.on_o),   32'(m_on[0]));
    chk("busy0", 32'(if0.busy_o), 32'(m_ena[0]));
    chk("ack0",  32'(if0.ack_o),  32'(req & {NR{m_on[0]}}));
    chk("ena1",  32'(if1.ena_o),  32'(m_ena[1]));
    chk("on1",   32'(if1.on_o),   32'(m_on[1]));
    chk("busy1", 32'(if1.busy_o), 32'(m_ena[1]));
    chk("ack1",  32'(if1.ack_o),  32'(req & {NR{m_on[1]}}));
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt;
    int ackhit;
    rst_n = 1'b0; req = '0; frc = 1'b0; hold = HW'(3);
    step(3);
    chk("rst_ena0", 32'(if0.ena_o), 0);
    chk("rst_on0", 32'(if0.on_o), 0);
    chk("rst_busy0", 32'(if0.busy_o), 0);
    rst_n = 1'b1;
    step(1);

    // single request, wake latency 2, close after hold=3
    req = 4'b0001;
    step(1); chk("t2_ena_e0", 32'(if0.ena_o), 1); chk("t2_on_e0", 32'(if0.on_o), 0);
    step(1); chk("t2_on_e1", 32'(if0.on_o), 0);
    step(1); chk("t2_on_e2", 32'(if0.on_o), 1); chk("t2_ack_e2", 32'(if0.ack_o), 4'b0001);
    step(5);
    req = '0; #1 chk("t2_ack_drop", 32'(if0.ack_o), 0);
    step(1); chk("t2_ena_f0", 32'(if0.ena_o), 1);
    step(1); chk("t2_ena_f1", 32'(if0.ena_o), 1);
    step(1); chk("t2_ena_f2", 32'(if0.ena_o), 1);
    step(1); chk("t2_ena_f3", 32'(if0.ena_o), 0);
    step(2);

    // re-request during hold
    req = 4'b0001; step(4);
    req = '0; step(2);
    req = 4'b0100; #1 chk("t3_ack_same", 32'(if0.ack_o), 4'b0100);
    chk("t3_ena_kept", 32'(if0.ena_o), 1);
    step(3); chk("t3_on", 32'(if0.on_o), 1);
    req = '0; step(6); chk("t3_closed", 32'(if0.ena_o), 0);
    step(2);

    // one-cycle pulse: wake 2 + on 1 + hold 3 = 6 open cycles
    req = 4'b0010; step(1); req = '0;
    cnt = 0; ackhit = 0;
    for (int k = 0; k < 10; k++) begin
      if (if0.ena_o) cnt++;
      if (if0.ack_o != '0) ackhit++;
      step(1);
    end
    chk("t4_open_cycles", 32'(cnt), 6);
    chk("t4_no_ack", 32'(ackhit), 0);
    step(2);

    // async reset mid-hold
    req = 4'b0001; step(4); req = '0; step(2);
    chk("t1_busy_pre", 32'(if0.busy_o), 1);
    #1 rst_n = 1'b0;
    #1 chk("t1_ena", 32'(if0.ena_o), 0); chk("t1_on", 32'(if0.on_o), 0);
    chk("t1_busy", 32'(if0.busy_o), 0); chk("t1_ack", 32'(if0.ack_o), 0);
    step(2); rst_n = 1'b1;
    step(1); chk("t1_off_after", 32'(if0.busy_o), 0);

    // zero wake, zero hold
    hold = '0; req = 4'b1000;
    step(1); chk("t5_ena", 32'(if1.ena_o), 1); chk("t5_on", 32'(if1.on_o), 1);
    req = '0;
    step(1); chk("t5_close", 32'(if1.ena_o), 0);
    step(4); hold = HW'(3);

    // force keeps the gate open regardless of requesters
    frc = 1'b1; req = '0;
    step(3); chk("t6_on", 32'(if0.on_o), 1); chk("t6_ack", 32'(if0.ack_o), 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      req = NR'($urandom);
      step(1);
      if (!if0.ena_o) cnt++;
    end
    chk("t6_never_closed", 32'(cnt), 0);
    frc = 1'b0; req = '0; step(8);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0)
        req = ($urandom_range(0, 9) < 6) ? '0 : NR'($urandom);
      if ($urandom_range(0, 39) == 0) frc = ~frc;
      if ($urandom_range(0, 9) == 0) hold = HW'($urandom_range(0, 5));
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
